// File: rtl/fastborrow_sub16.sv
// fastborrow_sub16 -- multi-cycle 16-bit subtractor, one 4-bit nibble per clock.
// Each nibble resolves its internal borrows with two-level lookahead, and the
// borrow between nibbles is carried in a register.
//
// Ports:
//   clk   in   1   clock, rising edge
//   rst   in   1   asynchronous active-high reset
//   start in   1   request pulse, accepted only while idle
//   A     in  16   minuend, sampled on the accepting edge
//   B     in  16   subtrahend, sampled on the accepting edge
//   Bin   in   1   borrow-in, sampled on the accepting edge
//   D     out 16   registered difference A - B - Bin (mod 2^16)
//   Bout  out  1   registered borrow-out
//   Ovf   out  1   registered two's-complement overflow
//   Zero  out  1   registered D == 0 flag
//   busy  out  1   high from acceptance until the done cycle ends
//   done  out  1   one-cycle pulse when the result registers update
module fastborrow_sub16 (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] A,
   input  logic [15:0] B,
   input  logic        Bin,
   output logic [15:0] D,
   output logic        Bout,
   output logic        Ovf,
   output logic        Zero,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state_r;
   logic [15:0] a_r;
   logic [15:0] b_r;
   logic [15:0] diff_r;
   logic [1:0]  k_r;
   logic        borrow_r;

   logic [3:0]  a_nib_s;
   logic [3:0]  b_nib_s;
   logic [4:0]  nib_res_s;
   logic [15:0] diff_next_s;

   // Nibble subtract: returns {borrow_out, diff[3:0]}. Every borrow is a flat
   // sum of products of g/p and the incoming borrow, so no bit waits on the
   // borrow of the bit below it.
   function automatic logic [4:0] nib_sub(input logic [3:0] a,
                                          input logic [3:0] b,
                                          input logic       c0);
      logic [3:0] p;
      logic [3:0] g;
      logic [3:0] d;
      logic       c1;
      logic       c2;
      logic       c3;
      logic       c4;
      p  = ~(a ^ b);
      g  = ~a & b;
      c1 = g[0] | (p[0] & c0);
      c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
      c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c0);
      c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c0);
      d  = a ^ b ^ {c3, c2, c1, c0};
      return {c4, d};
   endfunction

   // Select the active nibble and merge its result into the working difference.
   always_comb begin
      a_nib_s     = 4'h0;
      b_nib_s     = 4'h0;
      diff_next_s = diff_r;
      case (k_r)
         2'd0: begin a_nib_s = a_r[3:0];   b_nib_s = b_r[3:0];   end
         2'd1: begin a_nib_s = a_r[7:4];   b_nib_s = b_r[7:4];   end
         2'd2: begin a_nib_s = a_r[11:8];  b_nib_s = b_r[11:8];  end
         2'd3: begin a_nib_s = a_r[15:12]; b_nib_s = b_r[15:12]; end
         default: begin a_nib_s = 4'h0; b_nib_s = 4'h0; end
      endcase
      nib_res_s = nib_sub(a_nib_s, b_nib_s, borrow_r);
      case (k_r)
         2'd0:    diff_next_s[3:0]   = nib_res_s[3:0];
         2'd1:    diff_next_s[7:4]   = nib_res_s[3:0];
         2'd2:    diff_next_s[11:8]  = nib_res_s[3:0];
         2'd3:    diff_next_s[15:12] = nib_res_s[3:0];
         default: diff_next_s        = diff_r;
      endcase
   end

   // Control FSM, working registers and registered result outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r  <= IDLE;
         a_r      <= 16'h0000;
         b_r      <= 16'h0000;
         diff_r   <= 16'h0000;
         k_r      <= 2'd0;
         borrow_r <= 1'b0;
         D        <= 16'h0000;
         Bout     <= 1'b0;
         Ovf      <= 1'b0;
         Zero     <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (start) begin
                  a_r      <= A;
                  b_r      <= B;
                  diff_r   <= 16'h0000;
                  k_r      <= 2'd0;
                  borrow_r <= Bin;
                  busy     <= 1'b1;
                  state_r  <= RUN;
               end else begin
                  state_r  <= IDLE;
               end
            end
            RUN: begin
               diff_r   <= diff_next_s;
               borrow_r <= nib_res_s[4];
               k_r      <= k_r + 2'd1;
               if (k_r == 2'd3) begin
                  D       <= diff_next_s;
                  Bout    <= nib_res_s[4];
                  // Operands of opposite sign and a result whose sign differs from A.
                  Ovf     <= (a_r[15] ^ b_r[15]) & (diff_next_s[15] ^ a_r[15]);
                  Zero    <= (diff_next_s == 16'h0000);
                  done    <= 1'b1;
                  state_r <= DONE;
               end else begin
                  state_r <= RUN;
               end
            end
            DONE: begin
               done    <= 1'b0;
               busy    <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               done    <= 1'b0;
               busy    <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/fastborrow_sub16.md
FASTBORROW_SUB16 -- requirements
Module: fastborrow_sub16

Interface
REQ-001 Parameters: none.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request pulse; accepted only in IDLE.
REQ-005 A  input  16  minuend; sampled on the accepting edge.
REQ-006 B  input  16  subtrahend; sampled on the accepting edge.
REQ-007 Bin  input  1  borrow-in; sampled on the accepting edge.
REQ-008 D  output  16  registered difference A - B - Bin (mod 2^16).
REQ-009 Bout  output  1  registered borrow-out; 1 when A < B + Bin (unsigned).
REQ-010 Ovf  output  1  registered two's-complement overflow flag.
REQ-011 Zero  output  1  registered flag; 1 when D == 0.
REQ-012 busy  output  1  high while a subtraction is in progress.
REQ-013 done  output  1  one-cycle pulse; marks D, Bout, Ovf and Zero as updated.

Function
REQ-014 FSM has three states: IDLE, RUN and DONE. It resets to IDLE.
REQ-015 IDLE and start=1 on an edge: latch A, B and Bin into working registers, set nibble counter k=0, set borrow register to Bin, go to RUN.
REQ-016 IDLE and start=0: remain in IDLE; outputs hold their values.
REQ-017 RUN, one nibble per edge, nibble k = bits [4k+3:4k]:
- per bit: p = ~(a ^ b), g = ~a & b, d = a ^ b ^ borrow-in.
- borrows inside the nibble use lookahead: c[i+1] = g[i] | p[i]&c[i], with every term expanded to two-level form (no ripple chain).
- write the nibble difference into the working diff register.
- load the borrow register with the nibble borrow-out.
- increment k.
REQ-018 RUN with k==3 on an edge: complete the last nibble, then:
- load D from the working diff register.
- load Bout from the final borrow.
- load Ovf = (A[15] != B[15]) & (D[15] != A[15]), using the latched A and B.
- load Zero = (D == 0).
- go to DONE.
REQ-019 Total latency is 4 edges from acceptance. If start is sampled at edge N, done is high in the cycle following edge N+4.
REQ-020 DONE lasts exactly one cycle, then returns to IDLE unconditionally. done=1 only in DONE.
REQ-021 busy=1 in RUN and DONE; busy=0 in IDLE.
REQ-022 start while in RUN or DONE is ignored: no re-latching and no queuing. A new start is accepted in the first IDLE cycle.
REQ-023 Changes on A, B or Bin after acceptance do not affect the result in progress.
REQ-024 D, Bout, Ovf and Zero change only at the RUN-to-DONE edge. They hold until the next completion.
REQ-025 The result is bit-exact to (A - B - Bin) mod 2^16 for all 2^33 input combinations. Bout equals bit 16 of the 17-bit difference.

Reset
REQ-026 rst=1 forces, immediately and without waiting for a clock edge:
- state=IDLE, k=0, working registers=0.
- D=0, Bout=0, Ovf=0, Zero=0, busy=0, done=0.
REQ-027 Reset asserted during RUN aborts the operation; no done pulse is produced.
REQ-028 The first start accepted after rst deasserts behaves identically to a start accepted after power-up.

Verification
REQ-029 A=0x1234, B=0x0234, Bin=0, start at edge N -> done in the cycle after N+4; D=0x1000, Bout=0, Ovf=0, Zero=0.
REQ-030 A=0x0100, B=0x0001, Bin=0 -> D=0x00FF, Bout=0 (borrow crosses two nibble boundaries). Then A=0x0000, B=0x0001 -> D=0xFFFF, Bout=1, Ovf=0.
REQ-031 A=0x8000, B=0x0001, Bin=0 -> D=0x7FFF, Bout=0, Ovf=1. Then A=0x7FFF, B=0xFFFF -> D=0x8000, Bout=1, Ovf=1.
REQ-032 A=0x5555, B=0x5554, Bin=1 -> D=0x0000, Zero=1, Bout=0.
REQ-033 start pulsed again two cycles after acceptance with different A and B -> ignored; first result unchanged; busy stays high for exactly 5 cycles.
REQ-034 rst asserted between clock edges during RUN (k=2) -> all outputs 0 immediately, no done pulse. After release, A=0xFFFF, B=0x0001 -> D=0xFFFE.
REQ-035 Randomized check of at least 10,000 operations against the reference model (A - B - Bin); D, Bout, Ovf and Zero must match on every done pulse.
